// File: rtl/prbs_checker_param_pkg.sv
// Shared PRBS definitions for checkers and generators.
//   prbs_mode_e : 2-bit polynomial select (PRBS7/15/23/31)
//   chk_state_e : checker FSM state encoding
//   tap_n/tap_m : (N,M) tap pair for x^N + x^M + 1
//   prbs_fb     : feedback bit from a history vector, h[0] = newest bit
package prbs_checker_param_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS23 = 2'd2,
    MODE_PRBS31 = 2'd3
  } prbs_mode_e;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  localparam int HIST_W = 31;

  localparam logic [4:0] PRBS7_N  = 5'd7;
  localparam logic [4:0] PRBS7_M  = 5'd6;
  localparam logic [4:0] PRBS15_N = 5'd15;
  localparam logic [4:0] PRBS15_M = 5'd14;
  localparam logic [4:0] PRBS23_N = 5'd23;
  localparam logic [4:0] PRBS23_M = 5'd18;
  localparam logic [4:0] PRBS31_N = 5'd31;
  localparam logic [4:0] PRBS31_M = 5'd28;

  function automatic logic [4:0] tap_n(input prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return PRBS7_N;
      MODE_PRBS15: return PRBS15_N;
      MODE_PRBS23: return PRBS23_N;
      default:     return PRBS31_N;
    endcase
  endfunction

  function automatic logic [4:0] tap_m(input prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return PRBS7_M;
      MODE_PRBS15: return PRBS15_M;
      MODE_PRBS23: return PRBS23_M;
      default:     return PRBS31_M;
    endcase
  endfunction

  // Next bit of the sequence given the last HIST_W bits (h[0] newest).
  function automatic logic prbs_fb(input logic [HIST_W-1:0] h, input prbs_mode_e m);
    logic [4:0] n;
    logic [4:0] k;
    n = tap_n(m) - 5'd1;
    k = tap_m(m) - 5'd1;
    return h[n] ^ h[k];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rstn  : synchronous reset, active-high
//   clr   : synchronous clear (wins over inc)
//   inc   : count enable, one step per cycle
//   count : current value, holds at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rstn || clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_checker_param.sv
// Serial PRBS checker with auto-lock, windowed loss-of-lock detection and
// saturating bit/error/lock-loss statistics.
//   clk              : clock, rising edge
//   rstn             : synchronous reset, active-high
//   data_in          : received serial bit
//   data_in_valid    : data_in qualifier, one bit per valid cycle
//   mode             : 0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31
//   clear            : synchronous clear of the statistics counters
//   locked           : high while the checker is in lock
//   total_bits       : bits checked while locked
//   total_bit_errors : mismatches while locked
//   lock_loss_count  : lock losses due to error threshold, saturating
module prbs_checker_param #(
  parameter int CNT_W      = 32,
  parameter int LOCK_LEN   = 32,
  parameter int WIN_LEN    = 64,
  parameter int ERR_THRESH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             data_in,
  input  logic             data_in_valid,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             locked,
  output logic [CNT_W-1:0] total_bits,
  output logic [CNT_W-1:0] total_bit_errors,
  output logic [7:0]       lock_loss_count
);

  import prbs_checker_param_pkg::*;

  localparam int MATCH_W = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);
  localparam int WIN_W   = (WIN_LEN < 2) ? 1 : $clog2(WIN_LEN + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_LEN - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);

  chk_state_e         state;
  logic [HIST_W-1:0]  hist;
  logic [4:0]         seed_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [WIN_W-1:0]   win_bits;
  logic [WIN_W-1:0]   win_errs;
  logic [1:0]         mode_prev;
  logic               locked_r;

  prbs_mode_e       mode_e;
  logic             mode_chg;
  logic             exp_bit;
  logic             bit_err;
  logic [4:0]       seed_last;
  logic [WIN_W-1:0] err_next;
  logic             chk_vld;
  logic             in_lock;
  logic             thresh_hit;
  logic             bits_inc;
  logic             err_inc;

  assign mode_e     = prbs_mode_e'(mode);
  assign mode_chg   = (mode != mode_prev);
  assign exp_bit    = prbs_fb(hist, mode_e);
  assign bit_err    = data_in ^ exp_bit;
  assign seed_last  = tap_n(mode_e) - 5'd1;
  assign err_next   = win_errs + WIN_W'(bit_err);
  // A valid bit arriving together with a mode change is discarded.
  assign chk_vld    = data_in_valid && !mode_chg;
  assign in_lock    = (state == ST_LOCKED);
  assign thresh_hit = in_lock && chk_vld && (32'(err_next) >= 32'(ERR_THRESH));
  assign bits_inc   = in_lock && chk_vld;
  assign err_inc    = bits_inc && bit_err;
  assign locked     = locked_r;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= ST_SEED;
      hist      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked_r  <= 1'b0;
      // Track the current mode so leaving reset is not seen as a change.
      mode_prev <= mode;
    end else begin
      mode_prev <= mode;
      if (mode_chg) begin
        state     <= ST_SEED;
        seed_cnt  <= '0;
        match_cnt <= '0;
        win_bits  <= '0;
        win_errs  <= '0;
        locked_r  <= 1'b0;
      end else if (data_in_valid) begin
        case (state)
          ST_SEED: begin
            hist <= {hist[HIST_W-2:0], data_in};
            if (seed_cnt == seed_last) begin
              state     <= ST_SEARCH;
              seed_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              seed_cnt <= seed_cnt + 5'd1;
            end
          end
          ST_SEARCH: begin
            hist <= {hist[HIST_W-2:0], data_in};
            if (!bit_err) begin
              if (match_cnt == MATCH_LAST) begin
                state     <= ST_LOCKED;
                locked_r  <= 1'b1;
                match_cnt <= '0;
                win_bits  <= '0;
                win_errs  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Free-run on the local sequence so a single line error is
            // not fed back into the history and counted again.
            hist <= {hist[HIST_W-2:0], exp_bit};
            if (thresh_hit) begin
              state    <= ST_SEED;
              locked_r <= 1'b0;
              seed_cnt <= '0;
              win_bits <= '0;
              win_errs <= '0;
            end else if (win_bits == WIN_LAST) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + 1'b1;
              win_errs <= err_next;
            end
          end
          default: begin
            state    <= ST_SEED;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_bits_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clear),
    .inc   (bits_inc),
    .count (total_bits)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clear),
    .inc   (err_inc),
    .count (total_bit_errors)
  );

  sat_counter #(.WIDTH(8)) u_loss_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clear),
    .inc   (thresh_hit),
    .count (lock_loss_count)
  );

endmodule

// File: tb/tb_prbs_checker_param.sv
// Directed bench for prbs_checker_param: a table of PRBS stimulus steps with
// expected outputs, plus hand sequences for long-run lock, reset/clear
// mid-lock and counter saturation on a narrow-counter instance.
module tb_prbs_checker_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       data_in;
  logic       valid;
  logic       clear;
  logic       sel;
  logic [1:0] mode;
  logic       valid_a;
  logic       valid_b;

  logic        locked_a;
  logic [31:0] bits_a;
  logic [31:0] errs_a;
  logic [7:0]  loss_a;
  logic        locked_b;
  logic [3:0]  bits_b;
  logic [3:0]  errs_b;
  logic [7:0]  loss_b;

  assign valid_a = valid & ~sel;
  assign valid_b = valid & sel;

  prbs_checker_param dut_a (
    .clk              (clk),
    .rstn             (rstn),
    .data_in          (data_in),
    .data_in_valid    (valid_a),
    .mode             (mode),
    .clear            (clear),
    .locked           (locked_a),
    .total_bits       (bits_a),
    .total_bit_errors (errs_a),
    .lock_loss_count  (loss_a)
  );

  prbs_checker_param #(.CNT_W(4), .ERR_THRESH(255)) dut_b (
    .clk              (clk),
    .rstn             (rstn),
    .data_in          (data_in),
    .data_in_valid    (valid_b),
    .mode             (mode),
    .clear            (clear),
    .locked           (locked_b),
    .total_bits       (bits_b),
    .total_bit_errors (errs_b),
    .lock_loss_count  (loss_b)
  );

  int total = 0;
  int bad   = 0;

  logic [30:0] g;
  logic [1:0]  gmode;

  typedef enum int {OP_CLEAN, OP_FLIP, OP_IDLE, OP_CLEAR} op_e;
  typedef struct {
    op_e         op;
    logic [1:0]  mode;
    int          n;
    logic        exp_locked;
    logic [31:0] exp_bits;
    logic [31:0] exp_errs;
    logic [31:0] exp_loss;
  } vec_t;

  vec_t vecs[22];

  function automatic logic gen_next(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return s[6] ^ s[5];
      2'd1:    return s[14] ^ s[13];
      2'd2:    return s[22] ^ s[17];
      default: return s[30] ^ s[27];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int n, input bit flip);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = gen_next(g, gmode);
      g = {g[29:0], b};
      data_in = b ^ flip;
      valid = 1'b1;
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode  = m;
    gmode = m;
    g     = 31'h1;
    valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rstn    = 1'b1;
    valid   = 1'b1;
    data_in = 1'b1;
    clear   = 1'b1;
    tick();
    tick();
    rstn  = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    g     = 31'h1;
    tick();
  endtask

  task automatic check_a(input string tag, input logic l, input logic [31:0] b,
                         input logic [31:0] e, input logic [31:0] ls);
    check({tag, " locked"}, 32'(locked_a), 32'(l));
    check({tag, " total_bits"}, bits_a, b);
    check({tag, " total_bit_errors"}, errs_a, e);
    check({tag, " lock_loss_count"}, 32'(loss_a), ls);
  endtask

  initial begin
    //           op        mode  n   lock bits errs loss
    vecs[0]  = '{OP_CLEAN, 2'd0, 38,  1'b0, 0,   0, 0};
    vecs[1]  = '{OP_CLEAN, 2'd0, 1,   1'b1, 0,   0, 0};
    vecs[2]  = '{OP_CLEAN, 2'd0, 10,  1'b1, 10,  0, 0};
    vecs[3]  = '{OP_FLIP,  2'd0, 1,   1'b1, 11,  1, 0};
    vecs[4]  = '{OP_CLEAN, 2'd0, 20,  1'b1, 31,  1, 0};
    vecs[5]  = '{OP_CLEAN, 2'd0, 33,  1'b1, 64,  1, 0};
    vecs[6]  = '{OP_FLIP,  2'd0, 7,   1'b1, 71,  8, 0};
    vecs[7]  = '{OP_FLIP,  2'd0, 1,   1'b0, 72,  9, 1};
    vecs[8]  = '{OP_CLEAN, 2'd0, 38,  1'b0, 72,  9, 1};
    vecs[9]  = '{OP_CLEAN, 2'd0, 1,   1'b1, 72,  9, 1};
    vecs[10] = '{OP_IDLE,  2'd0, 5,   1'b1, 72,  9, 1};
    vecs[11] = '{OP_CLEAR, 2'd0, 1,   1'b1, 0,   0, 0};
    vecs[12] = '{OP_CLEAN, 2'd0, 5,   1'b1, 5,   0, 0};
    vecs[13] = '{OP_CLEAN, 2'd3, 62,  1'b0, 5,   0, 0};
    vecs[14] = '{OP_CLEAN, 2'd3, 1,   1'b1, 5,   0, 0};
    vecs[15] = '{OP_CLEAN, 2'd3, 100, 1'b1, 105, 0, 0};
    vecs[16] = '{OP_CLEAN, 2'd1, 46,  1'b0, 105, 0, 0};
    vecs[17] = '{OP_CLEAN, 2'd1, 1,   1'b1, 105, 0, 0};
    vecs[18] = '{OP_CLEAN, 2'd2, 54,  1'b0, 105, 0, 0};
    vecs[19] = '{OP_CLEAN, 2'd2, 1,   1'b1, 105, 0, 0};
    vecs[20] = '{OP_FLIP,  2'd2, 1,   1'b1, 106, 1, 0};
    vecs[21] = '{OP_CLEAN, 2'd2, 10,  1'b1, 116, 1, 0};

    sel     = 1'b0;
    clear   = 1'b0;
    valid   = 1'b0;
    data_in = 1'b0;
    mode    = 2'd0;
    gmode   = 2'd0;
    g       = 31'h1;
    do_reset();
    check_a("reset", 1'b0, 0, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].mode != gmode) begin
        set_mode(vecs[i].mode);
        check($sformatf("v%0d mode change locked", i), 32'(locked_a), 32'd0);
      end
      case (vecs[i].op)
        OP_CLEAN: send(vecs[i].n, 1'b0);
        OP_FLIP:  send(vecs[i].n, 1'b1);
        OP_IDLE: begin
          for (int k = 0; k < vecs[i].n; k++) begin
            data_in = 1'($urandom);
            valid   = 1'b0;
            tick();
          end
        end
        default: begin
          clear = 1'b1;
          send(vecs[i].n, 1'b0);
          clear = 1'b0;
        end
      endcase
      check_a($sformatf("v%0d", i), vecs[i].exp_locked, vecs[i].exp_bits,
              vecs[i].exp_errs, vecs[i].exp_loss);
    end

    // Long PRBS31 run from reset.
    mode  = 2'd3;
    gmode = 2'd3;
    do_reset();
    check_a("prbs31 reset", 1'b0, 0, 0, 0);
    send(62, 1'b0);
    check("prbs31 before lock", 32'(locked_a), 32'd0);
    send(1, 1'b0);
    check("prbs31 at lock", 32'(locked_a), 32'd1);
    send(10000 - 63, 1'b0);
    check_a("prbs31 10000", 1'b1, 9937, 0, 0);

    // Clear mid-lock with a valid bit in the same cycle.
    send(5, 1'b1);
    check_a("pre clear", 1'b1, 9942, 5, 0);
    clear = 1'b1;
    send(1, 1'b0);
    clear = 1'b0;
    check_a("clear mid-lock", 1'b1, 0, 0, 0);

    // Reset mid-lock with valid high; lock must be rebuilt from scratch.
    rstn    = 1'b1;
    valid   = 1'b1;
    data_in = 1'b1;
    tick();
    rstn  = 1'b0;
    valid = 1'b0;
    check_a("reset mid-lock", 1'b0, 0, 0, 0);
    send(62, 1'b0);
    check("relock after reset early", 32'(locked_a), 32'd0);
    send(1, 1'b0);
    check("relock after reset", 32'(locked_a), 32'd1);

    // Narrow counters saturate at 15.
    sel   = 1'b1;
    mode  = 2'd0;
    gmode = 2'd0;
    do_reset();
    send(39, 1'b0);
    check("narrow locked", 32'(locked_b), 32'd1);
    send(14, 1'b1);
    check("narrow errs 14", 32'(errs_b), 32'd14);
    check("narrow bits 14", 32'(bits_b), 32'd14);
    send(6, 1'b1);
    check("narrow errs sat", 32'(errs_b), 32'd15);
    check("narrow bits sat", 32'(bits_b), 32'd15);
    check("narrow still locked", 32'(locked_b), 32'd1);
    check("narrow loss", 32'(loss_b), 32'd0);
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
